// File: rtl/fmdll_pkg.sv
// Shared definitions for the FMDLL divider/ratio counters: channel state
// encoding and the default reset-modulus helper.
package fmdll_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // All-ones modulus for a given counter width, used as the reset modulus.
    function automatic int unsigned mod_rst_default(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/clock_counter_ch.sv
// One modulo counter channel: counts 1..mod_act and wraps, with a shadowed
// modulus that is only applied where it cannot push the count past the limit.
//
//   state   | meaning
//   --------+--------------------------------------------
//   ST_IDLE | count is 0; pending modulus applied next edge
//   ST_RUN  | count in 1..mod_act; pending waits for wrap
module clock_counter_ch
    import fmdll_pkg::*;
#(
    parameter int unsigned    W       = 4,
    parameter logic [W-1:0]   MOD_RST = '1
) (
    input  logic         clk_ext,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         mod_ld,
    input  logic [W-1:0] mod_in,
    output logic [W-1:0] count_out,
    output logic [W-1:0] mod_act,
    output logic         tc,
    output logic         ld_err
);

    ch_state_t    state_q;
    logic [W-1:0] count_q;
    logic [W-1:0] mod_act_q;
    logic [W-1:0] pend_q;
    logic         pend_vld_q;
    logic         tc_q;
    logic         ld_err_q;

    logic         load_ok;
    logic         load_zero;
    logic [W-1:0] pend_d;
    logic         pend_vld_d;
    logic         wrap;
    logic         apply;

    assign load_ok    = mod_ld && (mod_in != '0);
    assign load_zero  = mod_ld && (mod_in == '0);
    // A same-cycle valid load overrides the shadow so it can bypass on a wrap.
    assign pend_d     = load_ok ? mod_in : pend_q;
    assign pend_vld_d = load_ok || pend_vld_q;
    assign wrap       = (state_q == ST_RUN) && en && (count_q == mod_act_q);
    // Count is 0 or about to become 1 here, so any nonzero modulus is safe.
    assign apply      = clr || (state_q == ST_IDLE) || wrap;

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mod_act_q  <= MOD_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tc_q       <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            if (load_zero) begin
                ld_err_q <= 1'b1;
            end

            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d && !apply;
            if (apply && pend_vld_d) begin
                mod_act_q <= pend_d;
            end

            tc_q <= 1'b0;
            if (clr) begin
                count_q <= '0;
                state_q <= ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                if (en) begin
                    count_q <= W'(1);
                    state_q <= ST_RUN;
                end
            end else if (en) begin
                if (count_q == mod_act_q) begin
                    count_q <= W'(1);
                    tc_q    <= 1'b1;
                end else begin
                    count_q <= count_q + W'(1);
                end
            end
        end
    end

    assign count_out = count_q;
    assign mod_act   = mod_act_q;
    assign tc        = tc_q;
    assign ld_err    = ld_err_q;

endmodule

// File: rtl/clock_counter_bank.sv
// Bank of CH independent modulo counters for the FMDLL divider/ratio path;
// channel i occupies bits [i*W +: W] of each packed bus.
module clock_counter_bank
    import fmdll_pkg::*;
#(
    parameter int unsigned  W       = 4,
    parameter int unsigned  CH      = 2,
    parameter logic [W-1:0] MOD_RST = W'(mod_rst_default(W))
) (
    input  logic          clk_ext,
    input  logic          rst_n,
    input  logic [CH-1:0] en,
    input  logic [CH-1:0] clr,
    input  logic [CH-1:0] mod_ld,
    input  logic [CH*W-1:0] mod_in,
    output logic [CH*W-1:0] count_out,
    output logic [CH*W-1:0] mod_act,
    output logic [CH-1:0] tc,
    output logic [CH-1:0] ld_err
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clock_counter_ch #(
            .W       (W),
            .MOD_RST (MOD_RST)
        ) u_ch (
            .clk_ext   (clk_ext),
            .rst_n     (rst_n),
            .en        (en[i]),
            .clr       (clr[i]),
            .mod_ld    (mod_ld[i]),
            .mod_in    (mod_in[i*W +: W]),
            .count_out (count_out[i*W +: W]),
            .mod_act   (mod_act[i*W +: W]),
            .tc        (tc[i]),
            .ld_err    (ld_err[i])
        );
    end

endmodule

// File: tb/tb_clock_counter_bank.sv
// Directed self-checking bench for clock_counter_bank with W=4, CH=2,
// MOD_RST=15.
module tb_clock_counter_bank;

    logic       clk_ext = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] en      = '0;
    logic [1:0] clr     = '0;
    logic [1:0] mod_ld  = '0;
    logic [7:0] mod_in  = '0;
    logic [7:0] count_out;
    logic [7:0] mod_act;
    logic [1:0] tc;
    logic [1:0] ld_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] cnt0, cnt1, ma0, ma1;
    assign cnt0 = count_out[3:0];
    assign cnt1 = count_out[7:4];
    assign ma0  = mod_act[3:0];
    assign ma1  = mod_act[7:4];

    clock_counter_bank #(.W(4), .CH(2), .MOD_RST(4'd15)) dut (
        .clk_ext   (clk_ext),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .mod_ld    (mod_ld),
        .mod_in    (mod_in),
        .count_out (count_out),
        .mod_act   (mod_act),
        .tc        (tc),
        .ld_err    (ld_err)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic step;
        @(posedge clk_ext);
        #1;
    endtask

    task automatic do_reset;
        en = '0; clr = '0; mod_ld = '0; mod_in = '0;
        @(negedge clk_ext);
        rst_n = 1'b0;
        @(negedge clk_ext);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if (count_out !== 8'h00) begin
            failures++; $display("FAIL reset_count got=%h exp=00", count_out);
        end
        checks++;
        if (mod_act !== 8'hFF) begin
            failures++; $display("FAIL reset_mod_act got=%h exp=ff", mod_act);
        end
        checks++;
        if (tc !== 2'b00 || ld_err !== 2'b00) begin
            failures++; $display("FAIL reset_flags tc=%b ld_err=%b exp=00/00", tc, ld_err);
        end
    endtask

    task automatic test_count;
        do_reset();
        en = 2'b01;
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] exp_c;
            logic       exp_t;
            step();
            exp_c = (k <= 15) ? 4'(k) : 4'(k - 15);
            exp_t = (k == 16);
            checks++;
            if (cnt0 !== exp_c || tc[0] !== exp_t) begin
                failures++;
                $display("FAIL count_seq k=%0d got=%0d/tc%b exp=%0d/tc%b", k, cnt0, tc[0], exp_c, exp_t);
            end
            checks++;
            if (cnt1 !== 4'd0 || tc[1] !== 1'b0) begin
                failures++; $display("FAIL ch1_idle k=%0d got=%0d/tc%b exp=0/tc0", k, cnt1, tc[1]);
            end
        end
    endtask

    task automatic test_mod_decrease;
        do_reset();
        en = 2'b01;
        repeat (5) step();
        mod_ld = 2'b01; mod_in = 8'h03;
        step();
        mod_ld = '0; mod_in = '0;
        checks++;
        if (cnt0 !== 4'd6 || ma0 !== 4'd15) begin
            failures++; $display("FAIL dec_capture got=%0d/mod%0d exp=6/mod15", cnt0, ma0);
        end
        for (int k = 7; k <= 15; k++) begin
            step();
            checks++;
            if (cnt0 !== 4'(k) || ma0 !== 4'd15) begin
                failures++; $display("FAIL dec_run got=%0d/mod%0d exp=%0d/mod15", cnt0, ma0, k);
            end
        end
        for (int j = 0; j < 6; j++) begin
            logic [3:0] exp_c;
            step();
            exp_c = 4'((j % 3) + 1);
            checks++;
            if (cnt0 !== exp_c || ma0 !== 4'd3 || tc[0] !== (exp_c == 4'd1)) begin
                failures++;
                $display("FAIL dec_after_wrap j=%0d got=%0d/mod%0d/tc%b exp=%0d/mod3", j, cnt0, ma0, tc[0], exp_c);
            end
        end
    endtask

    task automatic test_wrap_load;
        do_reset();
        en = 2'b01;
        repeat (15) step();
        checks++;
        if (cnt0 !== 4'd15) begin
            failures++; $display("FAIL wrapld_pre got=%0d exp=15", cnt0);
        end
        mod_ld = 2'b01; mod_in = 8'h06;
        step();
        mod_ld = '0; mod_in = '0;
        checks++;
        if (cnt0 !== 4'd1 || ma0 !== 4'd6 || tc[0] !== 1'b1) begin
            failures++; $display("FAIL wrapld_bypass got=%0d/mod%0d/tc%b exp=1/mod6/tc1", cnt0, ma0, tc[0]);
        end
        for (int k = 2; k <= 6; k++) begin
            step();
            checks++;
            if (cnt0 !== 4'(k) || tc[0] !== 1'b0) begin
                failures++; $display("FAIL wrapld_run got=%0d/tc%b exp=%0d/tc0", cnt0, tc[0], k);
            end
        end
        step();
        checks++;
        if (cnt0 !== 4'd1 || tc[0] !== 1'b1) begin
            failures++; $display("FAIL wrapld_rewrap got=%0d/tc%b exp=1/tc1", cnt0, tc[0]);
        end
    endtask

    task automatic test_load_zero;
        do_reset();
        en = 2'b01;
        repeat (3) step();
        mod_ld = 2'b01; mod_in = 8'h05;
        step();
        mod_in = 8'h00;
        step();
        mod_ld = '0;
        checks++;
        if (cnt0 !== 4'd5 || ma0 !== 4'd15 || ld_err !== 2'b01) begin
            failures++; $display("FAIL zero_reject got=%0d/mod%0d/err%b exp=5/mod15/err01", cnt0, ma0, ld_err);
        end
        repeat (10) step();
        step();
        checks++;
        if (cnt0 !== 4'd1 || ma0 !== 4'd5 || tc[0] !== 1'b1 || ld_err !== 2'b01) begin
            failures++;
            $display("FAIL zero_keeps_pending got=%0d/mod%0d/tc%b/err%b exp=1/mod5/tc1/err01", cnt0, ma0, tc[0], ld_err);
        end
        mod_ld = 2'b01; mod_in = 8'h02;
        step();
        mod_ld = '0; mod_in = '0;
        repeat (4) step();
        checks++;
        if (cnt0 !== 4'd1 || ma0 !== 4'd2 || ld_err !== 2'b01) begin
            failures++; $display("FAIL zero_later_load got=%0d/mod%0d/err%b exp=1/mod2/err01", cnt0, ma0, ld_err);
        end
        do_reset();
        #1;
        checks++;
        if (ld_err !== 2'b00 || ma0 !== 4'd15) begin
            failures++; $display("FAIL zero_err_reset got=%b/mod%0d exp=00/mod15", ld_err, ma0);
        end
    endtask

    task automatic test_clr;
        do_reset();
        en = 2'b01;
        repeat (8) step();
        mod_ld = 2'b01; mod_in = 8'h04;
        step();
        mod_ld = '0; mod_in = '0;
        clr = 2'b01;
        step();
        clr = '0;
        checks++;
        if (cnt0 !== 4'd0 || ma0 !== 4'd4 || tc[0] !== 1'b0) begin
            failures++; $display("FAIL clr_apply got=%0d/mod%0d/tc%b exp=0/mod4/tc0", cnt0, ma0, tc[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (cnt0 !== 4'(k) || tc[0] !== 1'b0) begin
                failures++; $display("FAIL clr_run got=%0d/tc%b exp=%0d/tc0", cnt0, tc[0], k);
            end
        end
        step();
        checks++;
        if (cnt0 !== 4'd1 || tc[0] !== 1'b1) begin
            failures++; $display("FAIL clr_wrap got=%0d/tc%b exp=1/tc1", cnt0, tc[0]);
        end
    endtask

    task automatic test_mod_one;
        do_reset();
        clr = 2'b10; mod_ld = 2'b10; mod_in = 8'h10;
        step();
        clr = '0; mod_ld = '0; mod_in = '0;
        checks++;
        if (ma1 !== 4'd1 || cnt1 !== 4'd0 || ma0 !== 4'd15) begin
            failures++; $display("FAIL one_setup got=mod%0d/%0d ch0mod%0d exp=mod1/0 ch0mod15", ma1, cnt1, ma0);
        end
        en = 2'b10;
        step();
        checks++;
        if (cnt1 !== 4'd1 || tc[1] !== 1'b0) begin
            failures++; $display("FAIL one_enter got=%0d/tc%b exp=1/tc0", cnt1, tc[1]);
        end
        repeat (3) begin
            step();
            checks++;
            if (cnt1 !== 4'd1 || tc[1] !== 1'b1 || cnt0 !== 4'd0 || tc[0] !== 1'b0) begin
                failures++;
                $display("FAIL one_hold got=%0d/tc%b ch0=%0d/tc%b exp=1/tc1 ch0=0/tc0", cnt1, tc[1], cnt0, tc[0]);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        clr = 2'b01; mod_ld = 2'b01; mod_in = 8'h04;
        step();
        clr = '0; mod_ld = '0; mod_in = '0;
        en = 2'b01;
        repeat (3) step();
        checks++;
        if (cnt0 !== 4'd3 || ma0 !== 4'd4) begin
            failures++; $display("FAIL async_pre got=%0d/mod%0d exp=3/mod4", cnt0, ma0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cnt0 !== 4'd0 || ma0 !== 4'd15 || tc !== 2'b00) begin
            failures++; $display("FAIL async_immediate got=%0d/mod%0d/tc%b exp=0/mod15/tc00", cnt0, ma0, tc);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (cnt0 !== 4'd1 || ma0 !== 4'd15 || tc[0] !== 1'b0) begin
            failures++; $display("FAIL async_restart got=%0d/mod%0d/tc%b exp=1/mod15/tc0", cnt0, ma0, tc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_mod_decrease();
        test_wrap_load();
        test_load_zero();
        test_clr();
        test_mod_one();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
